mult_cmd_issuer: RTL and testbench

MULT_CMD_ISSUER -- requirements
Module: mult_cmd_issuer

---
 rtl/mult_cmd_issuer.sv | 197 +++++++++++++++++++
 tb/tb_mult_cmd_issuer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_cmd_issuer.sv
// Command FIFO plus single-in-flight issuer for a fixed-latency multiplier datapath.
// Define MULT_CMD_ISSUER_STATS_EN to add saturating issued_cnt/err_cnt outputs.
module mult_cmd_issuer #(
  parameter int unsigned DW    = 32,
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [1:0]      cmd_ww,
  input  logic [1:0]      cmd_ctrl,
  input  logic [DW-1:0]   cmd_a,
  input  logic [DW-1:0]   cmd_b,
  output logic [2:0]      dp_op,
  output logic [1:0]      dp_ww,
  output logic [1:0]      dp_ctrl,
  output logic [DW-1:0]   dp_A,
  output logic [DW-1:0]   dp_B,
  input  logic [2*DW-1:0] dp_Mout,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*DW-1:0] rsp_data,
  output logic            rsp_err,
  output logic            busy
`ifdef MULT_CMD_ISSUER_STATS_EN
  ,
  output logic [15:0]     issued_cnt,
  output logic [15:0]     err_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]    op;
    logic [1:0]    ww;
    logic [1:0]    ctrl;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b100);
  endfunction

  cmd_t          mem_q [DEPTH];
  cmd_t          cmd_in, head;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty, full, push, pop;

  state_t        state_q;
  logic [2:0]    wait_q;
  logic [2:0]    op_q;
  logic [2:0]    dp_op_q;
  logic [1:0]    dp_ww_q, dp_ctrl_q;
  logic [DW-1:0] dp_a_q, dp_b_q;
  logic          rsp_valid_q, rsp_err_q;
  logic [2*DW-1:0] rsp_data_q;

  assign cmd_in = {cmd_op, cmd_ww, cmd_ctrl, cmd_a, cmd_b};
  assign head   = mem_q[rptr_q];
  assign empty  = (count_q == '0);
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign push   = cmd_valid && !full;
  // The FIFO head is consumed when leaving IDLE or on the response handshake in HOLD.
  assign pop    = !empty && ((state_q == IDLE) || ((state_q == HOLD) && rsp_ready));

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      op_q        <= '0;
      dp_op_q     <= '0;
      dp_ww_q     <= '0;
      dp_ctrl_q   <= '0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q   <= ISSUE;
            op_q      <= head.op;
            dp_op_q   <= op_legal(head.op) ? head.op : 3'b000;
            dp_ww_q   <= head.ww;
            dp_ctrl_q <= head.ctrl;
            dp_a_q    <= head.a;
            dp_b_q    <= head.b;
          end
        end
        ISSUE: begin
          if (op_legal(op_q)) begin
            state_q <= WAIT;
            wait_q  <= 3'(LAT - 1);
          end else begin
            state_q     <= HOLD;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
          end
        end
        WAIT: begin
          if (wait_q == '0) begin
            state_q     <= HOLD;
            dp_op_q     <= 3'b000;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= dp_Mout;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (pop) begin
              state_q   <= ISSUE;
              op_q      <= head.op;
              dp_op_q   <= op_legal(head.op) ? head.op : 3'b000;
              dp_ww_q   <= head.ww;
              dp_ctrl_q <= head.ctrl;
              dp_a_q    <= head.a;
              dp_b_q    <= head.b;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready = !full;
  assign busy      = !empty || (state_q != IDLE);
  assign dp_op     = dp_op_q;
  assign dp_ww     = dp_ww_q;
  assign dp_ctrl   = dp_ctrl_q;
  assign dp_A      = dp_a_q;
  assign dp_B      = dp_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

`ifdef MULT_CMD_ISSUER_STATS_EN
  logic [15:0] issued_cnt_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      issued_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else if (state_q == ISSUE) begin
      if (op_legal(op_q)) begin
        if (issued_cnt_q != '1) issued_cnt_q <= issued_cnt_q + 16'd1;
      end else begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign issued_cnt = issued_cnt_q;
  assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_mult_cmd_issuer.sv
// Bench for mult_cmd_issuer: directed steps plus random traffic against an in-order response queue.
module tb_mult_cmd_issuer;
  localparam int unsigned DW = 32, LAT = 2, DEPTH = 4;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            cmd_valid, cmd_ready;
  logic [2:0]      cmd_op;
  logic [1:0]      cmd_ww, cmd_ctrl;
  logic [DW-1:0]   cmd_a, cmd_b;
  logic [2:0]      dp_op;
  logic [1:0]      dp_ww, dp_ctrl;
  logic [DW-1:0]   dp_A, dp_B;
  logic [2*DW-1:0] dp_Mout = '0;
  logic            rsp_valid, rsp_ready, rsp_err, busy;
  logic [2*DW-1:0] rsp_data;
`ifdef MULT_CMD_ISSUER_STATS_EN
  logic [15:0]     issued_cnt, err_cnt;
`endif

  always #5 clk = ~clk;

  mult_cmd_issuer #(.DW(DW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ww(cmd_ww), .cmd_ctrl(cmd_ctrl), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .dp_op(dp_op), .dp_ww(dp_ww), .dp_ctrl(dp_ctrl), .dp_A(dp_A), .dp_B(dp_B),
    .dp_Mout(dp_Mout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
`ifdef MULT_CMD_ISSUER_STATS_EN
    , .issued_cnt(issued_cnt), .err_cnt(err_cnt)
`endif
  );

  typedef struct {
    logic [2:0]    op;
    logic [1:0]    ww;
    logic [1:0]    ctrl;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } cmd_s;

  cmd_s exp_q[$];
  int   n_total = 0, n_pass = 0, n_fail = 0;
  int   accepted = 0;
  int   age = 0;

  function automatic bit legal(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2) || (op == 3'd4);
  endfunction

  // Stand-in datapath: multiply, add, and a swapped concatenation for the complex op.
  function automatic logic [2*DW-1:0] dp_model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] wa, wb;
    wa = {{DW{1'b0}}, a};
    wb = {{DW{1'b0}}, b};
    case (op)
      3'd1:    return wa * wb;
      3'd2:    return wa + wb;
      3'd4:    return {b, a};
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [2*DW-1:0] obs, input logic [2*DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Datapath model, scoreboard and handshake tracking, all sampled mid-cycle.
  always @(negedge clk) begin
    cmd_s e;
    if (n_rst !== 1'b0) begin
      exp_q.delete();
      age = 0;
      dp_Mout = {$urandom, $urandom};
    end else begin
      if (dp_op !== 3'b000) begin
        age++;
        check("dp_op_owner", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("dp_op", dp_op, legal(exp_q[0].op) ? exp_q[0].op : 3'd0);
          check("dp_ww_ctrl", {dp_ww, dp_ctrl}, {exp_q[0].ww, exp_q[0].ctrl});
        end
      end else begin
        if (age != 0) check("issue_len", age, LAT + 1);
        age = 0;
      end
      dp_Mout = (age == LAT + 1) ? dp_model(dp_op, dp_A, dp_B) : {$urandom, $urandom};
      if (rsp_valid === 1'b1) begin
        check("rsp_pending", exp_q.size() != 0, 1);
        if (rsp_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_err", rsp_err, !legal(e.op));
          check("rsp_data", rsp_data, legal(e.op) ? dp_model(e.op, e.a, e.b) : '0);
        end
      end
      if (cmd_valid && cmd_ready === 1'b1) begin
        exp_q.push_back('{cmd_op, cmd_ww, cmd_ctrl, cmd_a, cmd_b});
        accepted++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    cmd_op   = op;
    cmd_a    = a;
    cmd_b    = b;
    cmd_ww   = 2'($urandom);
    cmd_ctrl = 2'($urandom);
  endtask

  function automatic logic [2:0] pick_op();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 3) return 3'd1;
    if (r < 6) return 3'd2;
    if (r < 8) return 3'd4;
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) begin
        tick();
        check("drain_queue", exp_q.size(), 0);
        return;
      end
      tick();
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_rsp(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid) return;
      tick();
    end
    check("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic push_burst(input int n);
    cmd_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      set_cmd(pick_op() | 3'd0, $urandom, $urandom);
      if (!legal(cmd_op)) cmd_op = 3'd1;
      @(negedge clk);
      check("burst_accept", cmd_ready, 1);
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    n_rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_ww = '0; cmd_ctrl = '0; cmd_a = '0; cmd_b = '0;
    repeat (3) tick();

    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_dp_op", dp_op, 0);
    check("rst_dp_ab", {dp_A, dp_B}, 0);
    check("rst_dp_ww_ctrl", {dp_ww, dp_ctrl}, 0);
    check("rst_busy", busy, 0);
    tick();

    // First command presented on the very edge reset is released.
    n_rst = 1'b0; cmd_valid = 1'b1; set_cmd(3'd1, 7, 9);
    @(negedge clk);
    check("first_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle(50);

    // Single multiply 3*5, timed from ISSUE.
    rsp_ready = 1'b0; cmd_valid = 1'b1; set_cmd(3'd1, 3, 5);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int c = 0; c <= int'(LAT); c++) begin
      @(negedge clk);
      check("mul_dp_op", dp_op, 3'd1);
      check("mul_dp_ab", {dp_A, dp_B}, {32'd3, 32'd5});
      check("mul_rsp_early", rsp_valid, 0);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("mul_rsp_valid", rsp_valid, 1);
      check("mul_rsp_data", rsp_data, 15);
      check("mul_rsp_err", rsp_err, 0);
      check("mul_dp_op_hold", dp_op, 0);
      check("mul_dp_a_keep", dp_A, 3);
      tick();
    end
    rsp_ready = 1'b1;
    wait_idle(50);

    // Illegal op: response one cycle after ISSUE, datapath never driven.
    rsp_ready = 1'b0; cmd_valid = 1'b1; set_cmd(3'd3, $urandom, $urandom);
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("ill_rsp_early", rsp_valid, 0);
      check("ill_dp_op", dp_op, 0);
      tick();
    end
    @(negedge clk);
    check("ill_rsp_valid", rsp_valid, 1);
    check("ill_rsp_err", rsp_err, 1);
    check("ill_rsp_data", rsp_data, 0);
    check("ill_dp_op_hold", dp_op, 0);
`ifdef MULT_CMD_ISSUER_STATS_EN
    check("stat_err_cnt", err_cnt, 1);
    check("stat_issued_cnt", issued_cnt, 2);
`endif
    tick();
    rsp_ready = 1'b1;
    wait_idle(50);

    // Back-pressure: four queued plus one in flight closes the FIFO.
    rsp_ready = 1'b0;
    push_burst(5);
    cmd_valid = 1'b1; set_cmd(3'd2, $urandom, $urandom);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_full", cmd_ready, 0);
      check("bp_busy", busy, 1);
      tick();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle(100);

    // Push and pop on one edge with DEPTH-1 queued.
    rsp_ready = 1'b0;
    push_burst(DEPTH);
    wait_rsp(20);
    check("se_pre_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b1; rsp_ready = 1'b1; set_cmd(3'd4, $urandom, $urandom);
    tick();
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    check("se_count_same", cmd_ready, 1);
    tick();
    cmd_valid = 1'b1; set_cmd(3'd2, $urandom, $urandom);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("se_now_full", cmd_ready, 0);
    tick();
    rsp_ready = 1'b1;
    wait_idle(100);

    // Reset during WAIT with two commands still queued.
    rsp_ready = 1'b0;
    push_burst(3);
    n_rst = 1'b1;
    tick();
    n_rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_dp_op", dp_op, 0);
`ifdef MULT_CMD_ISSUER_STATS_EN
    check("mid_rst_stats", {issued_cnt, err_cnt}, 0);
`endif
    tick();
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("no_stale_rsp", rsp_valid, 0);
      tick();
    end

    // Random traffic; long enough to wrap the pointers several times.
    acc0 = accepted;
    for (int c = 0; c < 300; c++) begin
      cmd_valid = ($urandom_range(0, 9) < 6);
      set_cmd(pick_op(), $urandom, $urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle(200);
    check("wrap_cover", (accepted - acc0) >= 3 * int'(DEPTH), 1);

`ifdef MULT_CMD_ISSUER_STATS_EN
    force dut.issued_cnt_q = 16'hFFFE;
    tick();
    release dut.issued_cnt_q;
    rsp_ready = 1'b1;
    push_burst(3);
    wait_idle(100);
    check("stat_saturate", issued_cnt, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
